// File: rtl/uni_register_seq.sv
// Command sequencer for the 4-bit universal shift register.
// Each command loads a word, shifts it 0..4 places, then captures the result.
module uni_register_seq (
  input  logic       clk,
  input  logic       clear,
  input  logic       start,
  input  logic       dir,
  input  logic [2:0] count,
  input  logic [3:0] data_in,
  input  logic       ser_in,
  input  logic [3:0] q_in,
  output logic [1:0] modo,
  output logic [3:0] entparalela,
  output logic       serder,
  output logic       serizq,
  output logic       ser_out,
  output logic       busy,
  output logic       done,
  output logic [3:0] result
);

  typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;

  localparam logic [1:0] M_HOLD  = 2'b00;
  localparam logic [1:0] M_MSB   = 2'b01;
  localparam logic [1:0] M_LSB   = 2'b10;
  localparam logic [1:0] M_LOAD  = 2'b11;

  state_t     state, state_nx;
  logic [2:0] cnt;
  logic       dir_q;
  logic [2:0] cnt_clamp;

  // The register is only 4 bits wide, so shifting more than 4 is pointless.
  assign cnt_clamp = (count > 3'd4) ? 3'd4 : count;

  always_ff @(posedge clk) begin
    if (clear) state <= IDLE;
    else       state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      cnt         <= 3'd0;
      dir_q       <= 1'b0;
      entparalela <= 4'd0;
      result      <= 4'd0;
    end else begin
      case (state)
        IDLE: if (start) begin
          cnt         <= cnt_clamp;
          dir_q       <= dir;
          entparalela <= data_in;
        end
        SHIFT:   cnt    <= cnt - 3'd1;
        DONE:    result <= q_in;
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = LOAD;
      LOAD:    state_nx = (cnt == 3'd0) ? DONE : SHIFT;
      SHIFT:   if (cnt == 3'd1) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Serial steering is live only while shifting; the idle end of the
  // register always sees 0.
  always_comb begin
    modo    = M_HOLD;
    serder  = 1'b0;
    serizq  = 1'b0;
    ser_out = 1'b0;
    busy    = (state != IDLE);
    done    = 1'b0;
    case (state)
      LOAD:  modo = M_LOAD;
      SHIFT: begin
        modo    = dir_q ? M_LSB : M_MSB;
        serder  = dir_q ? 1'b0 : ser_in;
        serizq  = dir_q ? ser_in : 1'b0;
        ser_out = dir_q ? q_in[0] : q_in[3];
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/uni_register_seq.md
# uni_register_seq

Sequencer for the team's 4-bit universal shift register. It accepts a one-cycle start command, parallel-loads a word into the register, then shifts it a programmed number of positions in a chosen direction. While shifting it steers a serial input bit into the correct end of the register and presents the bit leaving the opposite end. It ends with a one-cycle done pulse and a captured copy of the final register contents. It sits between a command source (a UART- or SPI-style framer) and the register, and drives the register's mode, serial and parallel inputs.

## Interface
Parameters: none (fixed 4-bit register, 3-bit shift count).

Ports:
- clk  in  1  rising-edge clock shared with the register
- clear  in  1  synchronous, active-high reset; one clock; reset is synchronous and active-high
- start  in  1  command strobe, sampled only in IDLE
- dir  in  1  0 = shift toward MSB (serial in at bit 0); 1 = shift toward LSB (serial in at bit 3)
- count  in  3  number of shift cycles; 0 = load only; 5–7 clamp to 4
- data_in  in  4  word to load
- ser_in  in  1  serial bit inserted each shift cycle
- q_in  in  4  register's current Q
- modo  out  2  register mode: 00 hold, 01 shift toward MSB, 10 shift toward LSB, 11 parallel load
- entparalela  out  4  latched data_in
- serder  out  1  ser_in during SHIFT with dir=0, else 0
- serizq  out  1  ser_in during SHIFT with dir=1, else 0
- ser_out  out  1  q_in[3] (dir=0) or q_in[0] (dir=1) during SHIFT, else 0
- busy  out  1  high in LOAD, SHIFT and DONE
- done  out  1  one-cycle pulse in DONE
- result  out  4  q_in captured at the end of DONE; holds until the next capture

## Operation
- FSM states: IDLE, LOAD, SHIFT, DONE. Outputs modo, serder, serizq, ser_out, busy and done are Moore-decoded from the state register plus the latched dir.
- IDLE: modo=00. If start=1, latch data_in, dir, and min(count,4) into the remaining-shift counter; go to LOAD. Otherwise stay.
- LOAD: modo=11 for exactly one cycle, so the register loads entparalela at the end of LOAD. If the counter is 0, go to DONE; otherwise go to SHIFT.
- SHIFT: modo=01 (dir=0) or 10 (dir=1). Decrement the counter each cycle. When the counter reaches 1, go to DONE after that cycle.
- DONE: modo=00, done=1, result<=q_in at the end of the cycle; return to IDLE.
- start while busy=1 is ignored; no queuing. Inputs other than ser_in and q_in are not sampled outside the IDLE→LOAD transition.
- clear (any state, including mid-shift): next state IDLE.

## Timing
- Reset values after a clear edge: state IDLE, modo=00, entparalela=0000, serder=0, serizq=0, ser_out=0, busy=0, done=0, result=0000, counter=0.
- With start sampled at edge k and n = clamped count:
  - LOAD occupies cycle k..k+1.
  - SHIFT occupies n cycles.
  - done is high in the cycle ending at edge k+2+n.
  - result is valid from edge k+2+n.
  - The next start is accepted at edge k+3+n; earliest back-to-back period is n+3 cycles.
- Per shift cycle, ser_in is sampled by the register at the cycle-ending edge. ser_out is valid for the whole cycle before that edge.
- Simultaneous clear and start: clear wins and the command is dropped.
- If clear is shared with the register, Q is also 0000 after reset. If it is not shared, the register retains its content and modo=00 holds it.

## Test plan
- Reset: assert clear for 2 cycles mid-SHIFT, then release → all outputs at reset values, busy=0, and the next start is honoured normally.
- Load + shift toward MSB: data_in=1011, dir=0, count=2, ser_in=1 → modo sequence 11,01,01,00; Q 1011→0111→1111; done at k+4; result=1111.
- Shift toward LSB with serial out: data_in=1001, dir=1, count=4, ser_in=0 → ser_out sequence 1,0,0,1; serizq=0 and serder=0 throughout; result=0000; done at k+6.
- Load only and clamp:
  - count=0, data_in=0110 → modo 11 then 00; done at k+2; result=0110.
  - count=7 → exactly 4 SHIFT cycles.
- start held high continuously → commands accepted only in IDLE, every n+3 cycles; done never asserted in two consecutive cycles.
- Simultaneous clear and start in IDLE → remains IDLE, busy=0, modo=00, no LOAD cycle.
